// File: rtl/traffic_sequencer_pkg.sv
// Shared types for the traffic sequencer and its phase timer: state encoding,
// lamp codes, duration codes and the debug view of the controller.
package traffic_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_INIT_RED  = 3'd0,
      ST_NS_GREEN  = 3'd1,
      ST_NS_YELLOW = 3'd2,
      ST_RED_1     = 3'd3,
      ST_EW_GREEN  = 3'd4,
      ST_EW_YELLOW = 3'd5,
      ST_RED_2     = 3'd6
   } state_e;

   // Lamp buses are {red, yellow, green}.
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   typedef enum logic [1:0] {
      DUR_SHORT  = 2'b00,
      DUR_MEDIUM = 2'b01,
      DUR_LONG   = 2'b10
   } dur_e;

   typedef struct packed {
      state_e state;
      logic   entry;
      logic   ped_pending;
      logic   walk_grant;
   } seq_dbg_t;

   // Plain ring order; the NS_GREEN hold decision is made by the controller.
   function automatic state_e ring_next(input state_e s);
      state_e n;
      case (s)
         ST_INIT_RED:  n = ST_NS_GREEN;
         ST_NS_GREEN:  n = ST_NS_YELLOW;
         ST_NS_YELLOW: n = ST_RED_1;
         ST_RED_1:     n = ST_EW_GREEN;
         ST_EW_GREEN:  n = ST_EW_YELLOW;
         ST_EW_YELLOW: n = ST_RED_2;
         ST_RED_2:     n = ST_NS_GREEN;
         default:      n = ST_INIT_RED;
      endcase
      return n;
   endfunction

   function automatic dur_e phase_duration(input state_e s);
      dur_e d;
      case (s)
         ST_NS_GREEN: d = DUR_LONG;
         ST_EW_GREEN: d = DUR_MEDIUM;
         default:     d = DUR_SHORT;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/traffic_sequencer_ped.sv
// Pedestrian request latch: set by any request cycle, cleared on demand,
// with set taking priority when both happen together.
module traffic_sequencer_ped (
   input  logic clk,
   input  logic rst_n,
   input  logic set,
   input  logic clr,
   output logic pending
);

   logic pending_q;
   logic pending_d;

   always_comb begin
      pending_d = pending_q;
      if (clr) begin
         pending_d = 1'b0;
      end
      if (set) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/traffic_sequencer.sv
// Intersection phase controller: walks the NS/EW lamp ring, restarts an
// external phase timer on every state entry and serves pedestrian requests.
module traffic_sequencer
   import traffic_sequencer_pkg::*;
#(
   parameter bit SKIP_EW_IDLE = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ew_sensor,
   input  logic       ped_req,
   input  logic       timer_done,
   output logic       timer_start,
   output logic [1:0] duration_sel,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output seq_dbg_t   dbg
);

   // Timer handshake: timer_start is a one-cycle restart pulse issued in the
   // entry cycle; timer_done is a level that is only trusted once entry_q drops.
   state_e state_q;
   state_e state_d;
   logic   entry_q;
   logic   entry_d;
   logic   walk_grant_q;
   logic   walk_grant_d;

   logic   ped_pending;
   logic   ped_clr;
   logic   phase_done;
   logic   ew_demand;

   assign phase_done = timer_done & ~entry_q;
   assign ew_demand  = ew_sensor | ped_pending;
   assign ped_clr    = (state_q == ST_EW_GREEN) & entry_q;

   traffic_sequencer_ped u_ped (
      .clk     (clk),
      .rst_n   (rst_n),
      .set     (ped_req),
      .clr     (ped_clr),
      .pending (ped_pending)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_INIT_RED;
         entry_q      <= 1'b1;
         walk_grant_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         entry_q      <= entry_d;
         walk_grant_q <= walk_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      entry_d      = 1'b0;
      walk_grant_d = walk_grant_q;
      if (phase_done) begin
         entry_d = 1'b1;
         case (state_q)
            ST_NS_GREEN: begin
               // With no EW demand the green is simply re-armed in place.
               if (!(SKIP_EW_IDLE && !ew_demand)) begin
                  state_d      = ST_NS_YELLOW;
                  walk_grant_d = ped_pending;
               end
            end
            ST_EW_GREEN: begin
               state_d      = ST_EW_YELLOW;
               walk_grant_d = 1'b0;
            end
            default: begin
               state_d = ring_next(state_q);
            end
         endcase
      end
   end

   always_comb begin
      ns_light     = LAMP_RED;
      ew_light     = LAMP_RED;
      case (state_q)
         ST_NS_GREEN:  ns_light = LAMP_GRN;
         ST_NS_YELLOW: ns_light = LAMP_YEL;
         ST_EW_GREEN:  ew_light = LAMP_GRN;
         ST_EW_YELLOW: ew_light = LAMP_YEL;
         default: begin
            ns_light = LAMP_RED;
            ew_light = LAMP_RED;
         end
      endcase
      duration_sel = phase_duration(state_q);
      timer_start  = entry_q;
      walk         = walk_grant_q & (state_q == ST_EW_GREEN);
   end

   assign dbg = '{state: state_q, entry: entry_q, ped_pending: ped_pending,
                  walk_grant: walk_grant_q};

endmodule

// File: tb/tb_traffic_sequencer.sv
// Bench for traffic_sequencer: behavioural phase timer, dwell-count reference
// model feeding an expected queue, directed scenarios and a random soak.
module tb_traffic_sequencer;
  import traffic_sequencer_pkg::*;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam int P_INIT = 0, P_NSG = 1, P_NSY = 2, P_R1 = 3, P_EWG = 4, P_EWY = 5, P_R2 = 6;
  localparam bit SKIP = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ew_sensor = 1'b0;
  logic ped_req = 1'b0;
  logic hold_done = 1'b0;
  logic timer_done;
  logic timer_start;
  logic [1:0] duration_sel;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic walk;
  seq_dbg_t dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_sequencer #(.SKIP_EW_IDLE(SKIP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ew_sensor    (ew_sensor),
    .ped_req      (ped_req),
    .timer_done   (timer_done),
    .timer_start  (timer_start),
    .duration_sel (duration_sel),
    .ns_light     (ns_light),
    .ew_light     (ew_light),
    .walk         (walk),
    .dbg          (dbg)
  );

  // ---------------- phase timer (50/150/300) ----------------
  function automatic int dur_cycles(input logic [1:0] d);
    case (d)
      2'b01:   return 150;
      2'b10:   return 300;
      default: return 50;
    endcase
  endfunction

  int tmr_cnt = 0;
  int tmr_target = 50;
  logic tmr_done = 1'b0;

  always @(posedge clk) begin
    if (timer_start) begin
      tmr_cnt    <= 0;
      tmr_done   <= 1'b0;
      tmr_target <= dur_cycles(duration_sel);
    end else begin
      if (tmr_cnt >= tmr_target) tmr_done <= 1'b1;
      if (tmr_cnt < 100000) tmr_cnt <= tmr_cnt + 1;
    end
  end

  assign timer_done = tmr_done | hold_done;

  // ---------------- reference model ----------------
  // Each phase lasts its timer length + 3 cycles; cycle 0 of a visit is the entry.
  function automatic int dwell_of(input int ph);
    if (ph == P_NSG) return 300 + 3;
    if (ph == P_EWG) return 150 + 3;
    return 50 + 3;
  endfunction

  function automatic logic [10:0] expect_vec(input int ph, input int cnt, input bit wk, input bit pend);
    logic [2:0] ns;
    logic [2:0] ew;
    logic [1:0] d;
    ns = (ph == P_NSG) ? GRN : (ph == P_NSY) ? YEL : RED;
    ew = (ph == P_EWG) ? GRN : (ph == P_EWY) ? YEL : RED;
    d  = (ph == P_NSG) ? 2'd2 : (ph == P_EWG) ? 2'd1 : 2'd0;
    return {ns, ew, (ph == P_EWG) && wk, cnt == 0, d, pend};
  endfunction

  int m_ph = P_INIT;
  int m_cnt = 0;
  bit m_pend = 1'b0;
  bit m_walk = 1'b0;
  logic [10:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin : model
    int ph;
    int cnt;
    bit pend;
    bit wk;
    if (!rst_n) begin
      ph = P_INIT; cnt = 0; pend = 1'b0; wk = 1'b0;
      exp_q.delete();
    end else begin
      ph = m_ph; cnt = m_cnt; wk = m_walk;
      if (cnt == dwell_of(ph) - 1) begin
        cnt = 0;
        if (ph == P_NSG) begin
          if (!(SKIP && !ew_sensor && !m_pend)) begin
            ph = P_NSY;
            wk = m_pend;
          end
        end else begin
          ph = (ph == P_R2) ? P_NSG : ph + 1;
        end
      end else begin
        cnt = cnt + 1;
      end
      if (ped_req) pend = 1'b1;
      else if (m_ph == P_EWG && m_cnt == 0) pend = 1'b0;
      else pend = m_pend;
    end
    m_ph   <= ph;
    m_cnt  <= cnt;
    m_pend <= pend;
    m_walk <= wk;
    exp_q.push_back(expect_vec(ph, cnt, wk, pend));
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event at %0t", name, $time);
  endtask

  logic prev_start = 1'b0;
  logic prev_rst = 1'b0;

  always @(negedge clk) begin : compare
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      fail_now("exp_q_empty");
    end else begin
      e = exp_q.pop_front();
      check("ns_light", ns_light, e[10:8]);
      check("ew_light", ew_light, e[7:5]);
      check("walk", walk, e[4]);
      check("timer_start", timer_start, e[3]);
      check("duration_sel", duration_sel, e[2:1]);
      check("ped_pending", dbg.ped_pending, e[0]);
    end
    check("ns_onehot", $onehot(ns_light), 1);
    check("ew_onehot", $onehot(ew_light), 1);
    check("conflict", (ns_light != RED) && (ew_light != RED), 0);
    check("dur_11", duration_sel == 2'b11, 0);
    if (rst_n && prev_rst && prev_start) check("start_double", timer_start, 0);
    prev_start <= timer_start;
    prev_rst   <= rst_n;
  end

  // ---------------- driver tasks ----------------
  // Both tasks are entered and left at a negative clock edge.
  task automatic measure_run(input logic [2:0] ns, input logic [2:0] ew, output int n, output int w);
    n = 0;
    w = 0;
    while (ns_light === ns && ew_light === ew && n < 5000) begin
      n++;
      if (walk === 1'b1) w++;
      @(negedge clk);
    end
  endtask

  task automatic wait_lamp(input logic [2:0] ns, input logic [2:0] ew, input int limit, input string name);
    int k;
    k = 0;
    while (!(ns_light === ns && ew_light === ew)) begin
      if (k == limit) begin
        fail_now(name);
        return;
      end
      k++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_lamps(input string tag);
    check({tag, "_ns"}, ns_light, RED);
    check({tag, "_ew"}, ew_light, RED);
    check({tag, "_walk"}, walk, 0);
    check({tag, "_start"}, timer_start, 1);
    check({tag, "_dur"}, duration_sel, 2'b00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int w;
    int k;

    repeat (3) @(posedge clk);
    #1 check_reset_lamps("rst0");
    #1 rst_n = 1'b1;

    // Idle roads: INIT_RED then NS_GREEN re-arming in place.
    @(negedge clk);
    measure_run(RED, RED, n, w);
    check("init_len", n, 53);
    k = 0; w = 0;
    repeat (909) begin
      @(negedge clk);
      if (timer_start) k++;
      if (ew_light !== RED) w++;
    end
    check("idle_rearms", k, 3);
    check("idle_ew_lamp", w, 0);

    // Continuous EW demand: full ring.
    @(posedge clk); #2 ew_sensor = 1'b1;
    @(negedge clk);
    wait_lamp(YEL, RED, 400, "wait_nsy");
    measure_run(YEL, RED, n, w); check("nsy_len", n, 53);
    measure_run(RED, RED, n, w); check("red1_len", n, 53);
    measure_run(RED, GRN, n, w); check("ewg_len", n, 153); check("ewg_walk_off", w, 0);
    measure_run(RED, YEL, n, w); check("ewy_len", n, 53);
    measure_run(RED, RED, n, w); check("red2_len", n, 53);
    measure_run(GRN, RED, n, w); check("nsg_len", n, 303);

    // Single pedestrian pulse during NS_GREEN with no vehicles.
    @(posedge clk); #2 ew_sensor = 1'b0;
    @(negedge clk);
    wait_lamp(GRN, RED, 800, "wait_nsg3");
    repeat (10) @(negedge clk);
    @(posedge clk); #2 ped_req = 1'b1;
    @(posedge clk); #2 ped_req = 1'b0;
    @(negedge clk);
    wait_lamp(RED, GRN, 800, "wait_ewg3");
    measure_run(RED, GRN, n, w);
    check("ped_ewg_len", n, 153);
    check("ped_walk_len", w, 153);
    check("ped_cleared", dbg.ped_pending, 0);

    // Pedestrian pulse landing in the EW_GREEN entry cycle.
    @(posedge clk); #2 ew_sensor = 1'b1;
    k = 0;
    while (!(m_ph == P_EWG && m_cnt == 0) && k < 2000) begin
      @(posedge clk); #2;
      k++;
    end
    if (k == 2000) fail_now("wait_ewg_entry");
    ped_req = 1'b1;
    @(posedge clk); #2 ped_req = 1'b0; ew_sensor = 1'b0;
    @(negedge clk);
    measure_run(RED, GRN, n, w);
    check("late_ped_ewg_rest", n, 152);
    check("late_ped_walk_off", w, 0);
    wait_lamp(RED, GRN, 1500, "wait_ewg4b");
    measure_run(RED, GRN, n, w);
    check("late_ped_next_len", n, 153);
    check("late_ped_next_walk", w, 153);

    // Reset in the middle of EW_GREEN with a stuck-high timer_done.
    @(posedge clk); #2 ew_sensor = 1'b1;
    @(negedge clk);
    wait_lamp(RED, GRN, 1500, "wait_ewg5");
    repeat (20) @(negedge clk);
    @(posedge clk); #2 hold_done = 1'b1; rst_n = 1'b0;
    #1 check_reset_lamps("rst_mid");
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_init_c0_ns", ns_light, RED);
    @(posedge clk); #2 hold_done = 1'b0;
    @(negedge clk);
    measure_run(RED, RED, n, w);
    check("rst_init_len", n + 1, 53);

    // Random soak with occasional resets.
    repeat (20000) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 99) < 2) ew_sensor = ~ew_sensor;
      ped_req = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 7999) == 0) begin
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
      end
    end
    ped_req = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
